// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC owner and single-outstanding Wishbone instruction fetch sequencer.
// Define IF_MISALIGN_TRAP_EN to report misaligned redirect targets instead of aligning them.
module if_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o,
    output logic                  inst_fault_o
);
`ifdef IF_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, FLUSH, DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, flush_adr_q, flush_adr_d, inst_pc_q, inst_pc_d;
    logic [ADDR_WIDTH-1:0] tgt, fault_adr;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d, fault_q, fault_d, misaligned, go_fault;

    assign tgt        = TRAP ? redirect_pc_i : {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign fault_adr  = redirect_i ? tgt : pc_q;
    assign misaligned = TRAP && (fault_adr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_adr_d = flush_adr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        go_fault    = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d     = redirect_i ? tgt : pc_q;
                state_d  = redirect_i ? IDLE : REQ;
                go_fault = redirect_i && misaligned;
            end
            REQ: begin
                if (wb_ack_i && !redirect_i) begin
                    inst_d    = wb_dat_i;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    fault_d   = 1'b0;
                    pc_d      = pc_q + ADDR_WIDTH'(4);
                    state_d   = DONE;
                end else if (redirect_i) begin
                    pc_d        = tgt;
                    flush_adr_d = pc_q;
                    state_d     = wb_ack_i ? IDLE : FLUSH;
                    go_fault    = wb_ack_i && misaligned;
                end
            end
            FLUSH: begin
                pc_d     = redirect_i ? tgt : pc_q;
                state_d  = wb_ack_i ? IDLE : FLUSH;
                go_fault = wb_ack_i && misaligned;
            end
            DONE: begin
                if (redirect_i || !stall_i) begin
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    pc_d    = redirect_i ? tgt : pc_q;
                    state_d = redirect_i ? IDLE : REQ;
                end
                go_fault = redirect_i && misaligned;
            end
            default: state_d = IDLE;
        endcase
        // A misaligned target is presented as a faulting NOP without touching the bus.
        if (go_fault) begin
            state_d   = DONE;
            inst_d    = NOP;
            inst_pc_d = fault_adr;
            valid_d   = 1'b1;
            fault_d   = 1'b1;
            pc_d      = {fault_adr[ADDR_WIDTH-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= PC_ADDR;
            flush_adr_q <= PC_ADDR;
            inst_q      <= NOP;
            inst_pc_q   <= PC_ADDR;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_adr_q <= flush_adr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
        end
    end

    assign wb_cyc_o     = (state_q == REQ) || (state_q == FLUSH);
    assign wb_stb_o     = wb_cyc_o;
    assign wb_we_o      = 1'b0;
    assign wb_sel_o     = 4'b1111;
    assign wb_adr_o     = (state_q == FLUSH) ? flush_adr_q : pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign inst_fault_o = fault_q;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed cycle-by-cycle checks of fetch, stall, redirect, flush, reset and wrap.
module tb_if_fetch_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, inst_fault_o;
    int          checks = 0;
    int          errors = 0;

    if_fetch_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_valid_o(inst_valid_o), .inst_fault_o(inst_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input string tag, input logic [31:0] adr);
        check({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'd1);
        check({tag, "_stb"}, {31'b0, wb_stb_o}, 32'd1);
        check({tag, "_adr"}, wb_adr_o, adr);
        check({tag, "_nv"}, {31'b0, inst_valid_o}, 32'd0);
    endtask

    task automatic done(input string tag, input logic [31:0] inst, input logic [31:0] pc);
        check({tag, "_v"}, {31'b0, inst_valid_o}, 32'd1);
        check({tag, "_inst"}, inst_o, inst);
        check({tag, "_pc"}, inst_pc_o, pc);
        check({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
    endtask

    task automatic idle(input string tag);
        check({tag, "_cyc"}, {31'b0, wb_cyc_o}, 32'd0);
        check({tag, "_nv"}, {31'b0, inst_valid_o}, 32'd0);
    endtask

    task automatic reset_vals(input string tag);
        idle(tag);
        check({tag, "_adr"}, wb_adr_o, 32'h8000_0000);
        check({tag, "_inst"}, inst_o, 32'h0000_0013);
        check({tag, "_pc"}, inst_pc_o, 32'h8000_0000);
        check({tag, "_flt"}, {31'b0, inst_fault_o}, 32'd0);
    endtask

    initial begin
        tick;
        tick;
        reset_vals("rst");
        check("we", {31'b0, wb_we_o}, 32'd0);
        check("sel", {28'b0, wb_sel_o}, 32'hF);
        rst_i = 1'b0;
        idle("idle0");
        tick;
        // back-to-back zero-wait fetches
        for (int i = 0; i < 3; i++) begin
            req($sformatf("f%0d", i), 32'h8000_0000 + 32'(4 * i));
            wb_ack_i = 1'b1;
            wb_dat_i = 32'h1000 + 32'(i);
            tick;
            wb_ack_i = 1'b0;
            done($sformatf("d%0d", i), 32'h1000 + 32'(i), 32'h8000_0000 + 32'(4 * i));
            tick;
        end
        // delayed ack then stall in DONE
        for (int i = 0; i < 3; i++) begin
            req($sformatf("w%0d", i), 32'h8000_000C);
            tick;
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_0001;
        stall_i  = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            done($sformatf("st%0d", i), 32'hCAFE_0001, 32'h8000_000C);
            tick;
        end
        stall_i = 1'b0;
        done("st_rel", 32'hCAFE_0001, 32'h8000_000C);
        tick;
        // redirect while the fetch of 0x10 is outstanding
        req("r0", 32'h8000_0010);
        tick;
        req("r1", 32'h8000_0010);
        tick;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        tick;
        redirect_i = 1'b0;
        req("fl0", 32'h8000_0010);
        tick;
        req("fl1", 32'h8000_0010);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        tick;
        wb_ack_i = 1'b0;
        idle("fl_idle");
        tick;
        // redirect coincident with ack
        req("ra", 32'h8000_0100);
        wb_ack_i      = 1'b1;
        wb_dat_i      = 32'hDEAD_0002;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0200;
        tick;
        wb_ack_i   = 1'b0;
        redirect_i = 1'b0;
        idle("ra_idle");
        tick;
        req("rb", 32'h8000_0200);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_AAAA;
        tick;
        wb_ack_i = 1'b0;
        done("rb_d", 32'h0000_AAAA, 32'h8000_0200);
        // redirect beats stall in DONE
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0300;
        tick;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        idle("rs_idle");
        tick;
        req("rs", 32'h8000_0300);
        // reset mid-REQ with a late ack
        rst_i = 1'b1;
        tick;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h5555_5555;
        tick;
        reset_vals("mr");
        rst_i = 1'b0;
        tick;
        wb_ack_i = 1'b0;
        req("mr_f", 32'h8000_0000);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0777;
        tick;
        wb_ack_i = 1'b0;
        done("mr_d", 32'h0000_0777, 32'h8000_0000);
        // misaligned redirect target
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_0102;
        tick;
        redirect_i = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        done("mis_d", 32'h0000_0013, 32'h8000_0102);
        check("mis_flt", {31'b0, inst_fault_o}, 32'd1);
`else
        idle("mis_idle");
        check("mis_flt", {31'b0, inst_fault_o}, 32'd0);
`endif
        tick;
        req("mis_f", 32'h8000_0100);
        check("mis_flt_clr", {31'b0, inst_fault_o}, 32'd0);
        // PC wraps from the top of the address space
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick;
        redirect_i = 1'b0;
        req("wr_fl", 32'h8000_0100);
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        tick;
        req("wr_f", 32'hFFFF_FFFC);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_F00D;
        tick;
        wb_ack_i = 1'b0;
        done("wr_d", 32'h0BAD_F00D, 32'hFFFF_FFFC);
        tick;
        req("wr_0", 32'h0000_0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
